// File: rtl/reduce_pkg.sv
// Shared definitions for the pipelined reduction tree: mode encodings, packet
// state, elaboration-time sizing helpers and the per-bit reduction operator.
package reduce_pkg;

    localparam logic [1:0] RED_XOR  = 2'd0;
    localparam logic [1:0] RED_AND  = 2'd1;
    localparam logic [1:0] RED_OR   = 2'd2;
    localparam logic [1:0] RED_XNOR = 2'd3;

    typedef enum logic {
        PKT_IDLE = 1'b0,
        PKT_OPEN = 1'b1
    } pkt_state_e;

    function automatic int red_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Node count after k halving levels; odd leftovers survive one level unpaired.
    function automatic int red_nodes(input int n, input int k);
        int m;
        m = n;
        for (int i = 0; i < k; i++) m = (m + 1) / 2;
        return m;
    endfunction

    function automatic int red_stages(input int n, input int lps);
        return (red_clog2(n) + lps - 1) / lps;
    endfunction

    // XNOR is reduced as XOR; the single inversion happens at the tree output.
    function automatic logic red_op(input logic [1:0] mode, input logic a, input logic b);
        logic r;
        case (mode)
            RED_AND: r = a & b;
            RED_OR:  r = a | b;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/reduce_level.sv
// One level of the reduction tree: pairs nodes 2j/2j+1, passes an odd last node
// through untouched, and optionally registers data plus valid/sideband.
module reduce_level
    import reduce_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NIN   = 2,
    parameter bit REG   = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ce_i,
    input  logic             vld_i,
    input  logic [1:0]       mode_i,
    input  logic             first_i,
    input  logic             last_i,
    input  logic [WIDTH-1:0] d_i [NIN-1:0],
    output logic             vld_o,
    output logic [1:0]       mode_o,
    output logic             first_o,
    output logic             last_o,
    output logic [WIDTH-1:0] d_o [((NIN+1)/2)-1:0]
);

    localparam int NOUT = (NIN + 1) / 2;

    function automatic logic [WIDTH-1:0] red_vec(input logic [1:0] m,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = red_op(m, x[i], y[i]);
        return r;
    endfunction

    logic [WIDTH-1:0] node_d [NOUT-1:0];

    genvar gi;
    for (gi = 0; gi < NOUT; gi++) begin : g_node
        if (2 * gi + 1 < NIN) begin : g_pair
            assign node_d[gi] = red_vec(mode_i, d_i[2*gi], d_i[2*gi+1]);
        end else begin : g_pass
            assign node_d[gi] = d_i[2*gi];
        end
    end

    if (REG) begin : g_reg
        logic             vld_q;
        logic [1:0]       mode_q;
        logic             first_q;
        logic             last_q;
        logic [WIDTH-1:0] d_q [NOUT-1:0];

        // Payload only moves with a valid beat so bubbles leave the last data in place.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                vld_q   <= 1'b0;
                mode_q  <= RED_XOR;
                first_q <= 1'b0;
                last_q  <= 1'b0;
                for (int j = 0; j < NOUT; j++) d_q[j] <= '0;
            end else if (ce_i) begin
                vld_q <= vld_i;
                if (vld_i) begin
                    mode_q  <= mode_i;
                    first_q <= first_i;
                    last_q  <= last_i;
                    d_q     <= node_d;
                end
            end
        end

        assign vld_o   = vld_q;
        assign mode_o  = mode_q;
        assign first_o = first_q;
        assign last_o  = last_q;
        assign d_o     = d_q;
    end else begin : g_comb
        logic unused_ctl;
        assign unused_ctl = ^{clk_i, rst_i, ce_i};
        assign vld_o   = vld_i;
        assign mode_o  = mode_i;
        assign first_o = first_i;
        assign last_o  = last_i;
        assign d_o     = node_d;
    end

endmodule

// File: rtl/reduce_tree_pipe.sv
// Pipelined N-operand bitwise reduction with selectable mode, optional input and
// output registers, and a multi-beat packet accumulator after the result stage.
module reduce_tree_pipe
    import reduce_pkg::*;
#(
    parameter int N    = 8,
    parameter int W    = 32,
    parameter int LPS  = 1,
    parameter bit IREG = 1'b1,
    parameter bit OREG = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         ce_i,
    input  logic         vld_i,
    input  logic [1:0]   mode_i,
    input  logic         first_i,
    input  logic         last_i,
    input  logic [W-1:0] op_i [N-1:0],
    output logic         vld_o,
    output logic [W-1:0] res_o,
    output logic         acc_vld_o,
    output logic [W-1:0] acc_o
);

    localparam int D = red_clog2(N);

    function automatic logic [W-1:0] red_vec(input logic [1:0] m,
                                             input logic [W-1:0] x,
                                             input logic [W-1:0] y);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = red_op(m, x[i], y[i]);
        return r;
    endfunction

    logic         in_vld;
    logic [1:0]   in_mode;
    logic         in_first;
    logic         in_last;
    logic [W-1:0] in_op [N-1:0];

    if (IREG) begin : g_ireg
        logic         vld_q;
        logic [1:0]   mode_q;
        logic         first_q;
        logic         last_q;
        logic [W-1:0] op_q [N-1:0];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                vld_q   <= 1'b0;
                mode_q  <= RED_XOR;
                first_q <= 1'b0;
                last_q  <= 1'b0;
                for (int j = 0; j < N; j++) op_q[j] <= '0;
            end else if (ce_i) begin
                vld_q <= vld_i;
                if (vld_i) begin
                    mode_q  <= mode_i;
                    first_q <= first_i;
                    last_q  <= last_i;
                    op_q    <= op_i;
                end
            end
        end

        assign in_vld   = vld_q;
        assign in_mode  = mode_q;
        assign in_first = first_q;
        assign in_last  = last_q;
        assign in_op    = op_q;
    end else begin : g_icomb
        assign in_vld   = vld_i;
        assign in_mode  = mode_i;
        assign in_first = first_i;
        assign in_last  = last_i;
        assign in_op    = op_i;
    end

    logic         t_vld;
    logic [1:0]   t_mode;
    logic         t_first;
    logic         t_last;
    logic [W-1:0] t_raw;

    if (D == 0) begin : g_notree
        assign t_vld   = in_vld;
        assign t_mode  = in_mode;
        assign t_first = in_first;
        assign t_last  = in_last;
        assign t_raw   = in_op[0];
    end else begin : g_tree
        genvar gi;
        for (gi = 0; gi < D; gi++) begin : g_lvl
            localparam int NI = red_nodes(N, gi);
            localparam int NO = red_nodes(N, gi + 1);
            // Register closes every LPS-th level and always the final one.
            localparam bit R = ((gi % LPS) == (LPS - 1)) || (gi == D - 1);

            logic         lv_vld_i, lv_first_i, lv_last_i;
            logic [1:0]   lv_mode_i;
            logic [W-1:0] lv_d_i [NI-1:0];
            logic         lv_vld_o, lv_first_o, lv_last_o;
            logic [1:0]   lv_mode_o;
            logic [W-1:0] lv_d_o [NO-1:0];

            if (gi == 0) begin : g_src_in
                assign lv_vld_i   = in_vld;
                assign lv_mode_i  = in_mode;
                assign lv_first_i = in_first;
                assign lv_last_i  = in_last;
                assign lv_d_i     = in_op;
            end else begin : g_src_lvl
                assign lv_vld_i   = g_lvl[gi-1].lv_vld_o;
                assign lv_mode_i  = g_lvl[gi-1].lv_mode_o;
                assign lv_first_i = g_lvl[gi-1].lv_first_o;
                assign lv_last_i  = g_lvl[gi-1].lv_last_o;
                assign lv_d_i     = g_lvl[gi-1].lv_d_o;
            end

            reduce_level #(
                .WIDTH (W),
                .NIN   (NI),
                .REG   (R)
            ) u_level (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .ce_i    (ce_i),
                .vld_i   (lv_vld_i),
                .mode_i  (lv_mode_i),
                .first_i (lv_first_i),
                .last_i  (lv_last_i),
                .d_i     (lv_d_i),
                .vld_o   (lv_vld_o),
                .mode_o  (lv_mode_o),
                .first_o (lv_first_o),
                .last_o  (lv_last_o),
                .d_o     (lv_d_o)
            );
        end

        assign t_vld   = g_lvl[D-1].lv_vld_o;
        assign t_mode  = g_lvl[D-1].lv_mode_o;
        assign t_first = g_lvl[D-1].lv_first_o;
        assign t_last  = g_lvl[D-1].lv_last_o;
        assign t_raw   = g_lvl[D-1].lv_d_o[0];
    end

    logic [W-1:0] res_d;
    assign res_d = t_raw ^ {W{t_mode == RED_XNOR}};

    logic         b_vld;
    logic [1:0]   b_mode;
    logic         b_first;
    logic         b_last;
    logic [W-1:0] b_res;

    if (OREG) begin : g_oreg
        logic         vld_q;
        logic [1:0]   mode_q;
        logic         first_q;
        logic         last_q;
        logic [W-1:0] res_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                vld_q   <= 1'b0;
                mode_q  <= RED_XOR;
                first_q <= 1'b0;
                last_q  <= 1'b0;
                res_q   <= '0;
            end else if (ce_i) begin
                vld_q <= t_vld;
                if (t_vld) begin
                    mode_q  <= t_mode;
                    first_q <= t_first;
                    last_q  <= t_last;
                    res_q   <= res_d;
                end
            end
        end

        assign b_vld   = vld_q;
        assign b_mode  = mode_q;
        assign b_first = first_q;
        assign b_last  = last_q;
        assign b_res   = res_q;
    end else begin : g_ocomb
        assign b_vld   = t_vld;
        assign b_mode  = t_mode;
        assign b_first = t_first;
        assign b_last  = t_last;
        assign b_res   = res_d;
    end

    assign vld_o = b_vld;
    assign res_o = b_res;

    pkt_state_e   state_q, state_d;
    logic [W-1:0] acc_q, acc_d;
    logic [1:0]   acc_mode_q, acc_mode_d;
    logic [W-1:0] acc_out_q, acc_out_d;
    logic         acc_vld_q, acc_vld_d;
    logic         pkt_start;
    logic [1:0]   cmb_mode;
    logic [W-1:0] beat_raw;
    logic [W-1:0] cmb_val;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= PKT_IDLE;
            acc_q      <= '0;
            acc_mode_q <= RED_XOR;
            acc_out_q  <= '0;
            acc_vld_q  <= 1'b0;
        end else if (ce_i) begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            acc_mode_q <= acc_mode_d;
            acc_out_q  <= acc_out_d;
            acc_vld_q  <= acc_vld_d;
        end
    end

    // The accumulator works on pre-inversion beat values so an XNOR packet
    // inverts exactly once, on the packet result.
    always_comb begin
        pkt_start  = b_first || (state_q == PKT_IDLE);
        cmb_mode   = pkt_start ? b_mode : acc_mode_q;
        beat_raw   = b_res ^ {W{b_mode == RED_XNOR}};
        cmb_val    = pkt_start ? beat_raw : red_vec(acc_mode_q, acc_q, beat_raw);
        state_d    = state_q;
        acc_d      = acc_q;
        acc_mode_d = acc_mode_q;
        acc_out_d  = acc_out_q;
        acc_vld_d  = 1'b0;
        if (b_vld) begin
            if (b_last) begin
                acc_out_d = cmb_val ^ {W{cmb_mode == RED_XNOR}};
                acc_vld_d = 1'b1;
                state_d   = PKT_IDLE;
            end else begin
                acc_d      = cmb_val;
                acc_mode_d = cmb_mode;
                state_d    = PKT_OPEN;
            end
        end
    end

    assign acc_vld_o = acc_vld_q;
    assign acc_o     = acc_out_q;

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Scoreboard bench: stimulus pushes expected beat/packet results, negedge
// monitors pop and compare for three configurations sharing one stimulus.
module tb_reduce_tree_pipe;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        vld;
    logic [1:0]  mode;
    logic        first;
    logic        last;
    logic [31:0] op  [7:0];
    logic [31:0] op5 [4:0];
    logic [31:0] op1 [0:0];

    logic        vld_o, acc_vld_o;
    logic [31:0] res_o, acc_o;
    logic        n5_vld_o, n5_acc_vld_o;
    logic [31:0] n5_res_o, n5_acc_o;
    logic        n1_vld_o, n1_acc_vld_o;
    logic [31:0] n1_res_o, n1_acc_o;

    exp_t q_main[$];
    exp_t q_n5[$];
    exp_t q_n1[$];
    exp_t q_acc[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic ce_q = 1'b0;

    always_comb begin
        for (int k = 0; k < 5; k++) op5[k] = op[k];
        op1[0] = op[0];
    end

    reduce_tree_pipe #(.N(8), .W(32), .LPS(1), .IREG(1'b1), .OREG(1'b1)) u_main (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .vld_i(vld), .mode_i(mode),
        .first_i(first), .last_i(last), .op_i(op),
        .vld_o(vld_o), .res_o(res_o), .acc_vld_o(acc_vld_o), .acc_o(acc_o));

    reduce_tree_pipe #(.N(5), .W(32), .LPS(2), .IREG(1'b0), .OREG(1'b0)) u_n5 (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .vld_i(vld), .mode_i(mode),
        .first_i(first), .last_i(last), .op_i(op5),
        .vld_o(n5_vld_o), .res_o(n5_res_o), .acc_vld_o(n5_acc_vld_o), .acc_o(n5_acc_o));

    reduce_tree_pipe #(.N(1), .W(32), .LPS(1), .IREG(1'b1), .OREG(1'b1)) u_n1 (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .vld_i(vld), .mode_i(mode),
        .first_i(first), .last_i(last), .op_i(op1),
        .vld_o(n1_vld_o), .res_o(n1_res_o), .acc_vld_o(n1_acc_vld_o), .acc_o(n1_acc_o));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        ce_q <= ce;
        if (ce) cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Reference reduction over the first n operands, for the non-default configs.
    function automatic logic [31:0] model(input logic [1:0] m, input int n);
        logic [31:0] r;
        r = op[0];
        for (int k = 1; k < n; k++) begin
            case (m)
                2'd1:    r = r & op[k];
                2'd2:    r = r | op[k];
                default: r = r ^ op[k];
            endcase
        end
        if (m == 2'd3) r = ~r;
        return r;
    endfunction

    task automatic set_ops(input logic [31:0] fill);
        for (int k = 0; k < 8; k++) op[k] = fill;
    endtask

    task automatic send(input logic [1:0] m, input logic f, input logic l,
                        input logic [31:0] exp_res, input bit has_acc, input logic [31:0] exp_acc);
        mode  = m;
        first = f;
        last  = l;
        vld   = 1'b1;
        q_main.push_back('{exp_res, cyc});
        q_n5.push_back('{model(m, 5), cyc});
        q_n1.push_back('{model(m, 1), cyc});
        if (has_acc) q_acc.push_back('{exp_acc, cyc});
        $display("issue mode=%0d first=%0d last=%0d exp_res=%h", m, f, l, exp_res);
        @(posedge clk);
        #1;
        vld   = 1'b0;
        first = 1'b0;
        last  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q_main.size() + q_n5.size() + q_n1.size() + q_acc.size()) != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        n_cmp++;
        if (t >= 200) begin
            n_bad++;
            $display("FAIL drain_timeout: %0d results still pending, required 0",
                     q_main.size() + q_n5.size() + q_n1.size() + q_acc.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : mon_main
        exp_t e;
        if (!rst && ce_q && vld_o) begin
            if (q_main.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL main_unexpected: got res %h, required no beat", res_o);
            end else begin
                e = q_main.pop_front();
                check("main_res", res_o, e.val);
                check("main_lat", 32'(cyc - e.cyc), 32'd5);
                $display("main beat res=%h lat=%0d", res_o, cyc - e.cyc);
            end
        end
    end

    always @(negedge clk) begin : mon_acc
        exp_t e;
        if (!rst && ce_q && acc_vld_o) begin
            if (q_acc.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL acc_unexpected: got acc %h, required no packet", acc_o);
            end else begin
                e = q_acc.pop_front();
                check("acc_val", acc_o, e.val);
                check("acc_lat", 32'(cyc - e.cyc), 32'd6);
                $display("main packet acc=%h lat=%0d", acc_o, cyc - e.cyc);
            end
        end
    end

    always @(negedge clk) begin : mon_n5
        exp_t e;
        if (!rst && ce_q && n5_vld_o) begin
            if (q_n5.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL n5_unexpected: got res %h, required no beat", n5_res_o);
            end else begin
                e = q_n5.pop_front();
                check("n5_res", n5_res_o, e.val);
                check("n5_lat", 32'(cyc - e.cyc), 32'd2);
                $display("n5 beat res=%h lat=%0d", n5_res_o, cyc - e.cyc);
            end
        end
    end

    always @(negedge clk) begin : mon_n1
        exp_t e;
        if (!rst && ce_q && n1_vld_o) begin
            if (q_n1.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL n1_unexpected: got res %h, required no beat", n1_res_o);
            end else begin
                e = q_n1.pop_front();
                check("n1_res", n1_res_o, e.val);
                check("n1_lat", 32'(cyc - e.cyc), 32'd2);
                $display("n1 beat res=%h lat=%0d", n1_res_o, cyc - e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ce = 1'b1; vld = 1'b0; mode = 2'd0; first = 1'b0; last = 1'b0;
        set_ops(32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_vld_o", {31'd0, vld_o}, 32'd0);
        check("rst_res_o", res_o, 32'd0);
        check("rst_acc_vld_o", {31'd0, acc_vld_o}, 32'd0);
        check("rst_acc_o", acc_o, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single XOR beat of one-hot operands
        for (int k = 0; k < 8; k++) op[k] = 32'h1 << k;
        send(2'd0, 1'b1, 1'b1, 32'h0000_00FF, 1'b1, 32'h0000_00FF);
        drain();

        // AND with one odd operand, then OR of zeros
        set_ops(32'hFFFF_FFF0);
        op[5] = 32'h0F0F_FFFF;
        send(2'd1, 1'b1, 1'b1, 32'h0F0F_FFF0, 1'b1, 32'h0F0F_FFF0);
        set_ops(32'h0);
        send(2'd2, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_0000);
        drain();

        // Back-to-back beats, one per mode
        for (int k = 0; k < 8; k++) op[k] = 32'hFFFF_0000 | (32'h1 << k);
        send(2'd0, 1'b1, 1'b1, 32'h0000_00FF, 1'b1, 32'h0000_00FF);
        send(2'd1, 1'b1, 1'b1, 32'hFFFF_0000, 1'b1, 32'hFFFF_0000);
        send(2'd2, 1'b1, 1'b1, 32'hFFFF_00FF, 1'b1, 32'hFFFF_00FF);
        send(2'd3, 1'b1, 1'b1, 32'hFFFF_FF00, 1'b1, 32'hFFFF_FF00);
        drain();

        // Three-beat XOR packet
        set_ops(32'h0); op[0] = 32'h1;
        send(2'd0, 1'b1, 1'b0, 32'h1, 1'b0, 32'h0);
        op[0] = 32'h2;
        send(2'd0, 1'b0, 1'b0, 32'h2, 1'b0, 32'h0);
        op[0] = 32'h4;
        send(2'd0, 1'b0, 1'b1, 32'h4, 1'b1, 32'h7);
        drain();

        // Packet aborted by a second first
        op[0] = 32'h1;
        send(2'd0, 1'b1, 1'b0, 32'h1, 1'b0, 32'h0);
        op[0] = 32'h2;
        send(2'd0, 1'b1, 1'b0, 32'h2, 1'b0, 32'h0);
        op[0] = 32'h4;
        send(2'd0, 1'b0, 1'b1, 32'h4, 1'b1, 32'h6);
        drain();

        // XNOR packet inverts once over the whole packet
        set_ops(32'h0); op[0] = 32'h0F;
        send(2'd3, 1'b1, 1'b0, 32'hFFFF_FFF0, 1'b0, 32'h0);
        op[0] = 32'hF0;
        send(2'd3, 1'b0, 1'b1, 32'hFFFF_FF0F, 1'b1, 32'hFFFF_FF00);
        // Packet combines with the first beat's mode
        set_ops(32'hFFFF_FFFF); op[0] = 32'h0000_FFFF;
        send(2'd1, 1'b1, 1'b0, 32'h0000_FFFF, 1'b0, 32'h0);
        set_ops(32'h0); op[0] = 32'h00FF_00FF;
        send(2'd2, 1'b0, 1'b1, 32'h00FF_00FF, 1'b1, 32'h0000_00FF);
        // Beat without first while idle opens a packet
        set_ops(32'h0); op[0] = 32'h5;
        send(2'd0, 1'b0, 1'b1, 32'h5, 1'b1, 32'h5);
        drain();

        // Clock-enable freeze mid-stream
        for (int k = 0; k < 8; k++) op[k] = 32'hFFFF_0000 | (32'h1 << k);
        send(2'd0, 1'b1, 1'b1, 32'h0000_00FF, 1'b1, 32'h0000_00FF);
        send(2'd1, 1'b1, 1'b1, 32'hFFFF_0000, 1'b1, 32'hFFFF_0000);
        send(2'd2, 1'b1, 1'b1, 32'hFFFF_00FF, 1'b1, 32'hFFFF_00FF);
        send(2'd3, 1'b1, 1'b1, 32'hFFFF_FF00, 1'b1, 32'hFFFF_FF00);
        repeat (2) begin @(posedge clk); #1; end
        ce = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        check("frz_vld_o", {31'd0, vld_o}, 32'd1);
        check("frz_res_o", res_o, 32'hFFFF_0000);
        check("frz_acc_vld_o", {31'd0, acc_vld_o}, 32'd1);
        check("frz_acc_o", acc_o, 32'h0000_00FF);
        ce = 1'b1;
        drain();

        // Reset with an open packet and beats in flight
        set_ops(32'h0); op[0] = 32'h3;
        send(2'd0, 1'b1, 1'b0, 32'h3, 1'b0, 32'h0);
        repeat (6) begin @(posedge clk); #1; end
        op[0] = 32'h4;
        send(2'd0, 1'b0, 1'b0, 32'h4, 1'b0, 32'h0);
        op[0] = 32'h8;
        send(2'd0, 1'b0, 1'b1, 32'h8, 1'b0, 32'h0);
        #3;
        rst = 1'b1;
        #1;
        q_main.delete(); q_n5.delete(); q_n1.delete(); q_acc.delete();
        check("mid_rst_vld_o", {31'd0, vld_o}, 32'd0);
        check("mid_rst_res_o", res_o, 32'd0);
        check("mid_rst_acc_vld_o", {31'd0, acc_vld_o}, 32'd0);
        check("mid_rst_acc_o", acc_o, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        op[0] = 32'h9;
        send(2'd0, 1'b0, 1'b1, 32'h9, 1'b1, 32'h9);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
